// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - boot sequencer: packs a byte stream into imem words, then runs the CPU for a fixed cycle budget
module cpu_program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int CYC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYC_WIDTH-1:0]  run_cycles,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  cpu_clk_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RELEASE, S_RUN, S_DONE, S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-2:0] words_q, words_d;
  logic [CYC_WIDTH-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    last_d  = last_q;
    addr_d  = addr_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          buf_d   = '0;
          last_d  = 1'b0;
          addr_d  = '0;
          words_d = '0;
        end
      end
      S_LOAD: begin
        // Upper lanes are already zero because the buffer is cleared after every write.
        if (byte_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3 || byte_last) begin
            state_d = S_WRITE;
            last_d  = byte_last;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(4);
        words_d = words_q + (ADDR_WIDTH-1)'(1);
        buf_d   = '0;
        idx_d   = '0;
        if (last_q)                 state_d = S_RELEASE;
        else if (addr_q == TOP_ADDR) state_d = S_ERROR;
        else                        state_d = S_LOAD;
      end
      S_RELEASE: begin
        cnt_d   = run_cycles;
        state_d = (run_cycles == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q - CYC_WIDTH'(1);
        if (cnt_q == CYC_WIDTH'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output decodes from registered state so no input reaches an output combinationally.
  assign byte_ready   = (state_q == S_LOAD);
  assign imem_we      = (state_q == S_WRITE);
  assign imem_addr    = addr_q;
  assign imem_wdata   = buf_q;
  assign cpu_reset    = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                        (state_q == S_WRITE) || (state_q == S_ERROR);
  assign cpu_clk_en   = (state_q == S_RUN);
  assign busy         = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                        (state_q == S_RELEASE) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb/tb_cpu_program_loader.sv - directed self-checking bench for cpu_program_loader
module tb_cpu_program_loader;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_last = 1'b0;
  logic        byte_ready, imem_we, cpu_reset, cpu_clk_en, busy, done, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;

  logic        b_start = 1'b0;
  logic [15:0] b_run_cycles = '0;
  logic        b_valid = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_last = 1'b0;
  logic        b_byte_ready, b_imem_we, b_cpu_reset, b_cpu_clk_en, b_busy, b_done, b_error;
  logic [3:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic [2:0]  b_words_loaded;

  int vectors = 0;
  int miscompares = 0;

  cpu_program_loader #(.ADDR_WIDTH(10), .CYC_WIDTH(16)) dut_a (
    .clock(clock), .reset(rst_n), .start(start), .run_cycles(run_cycles),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  cpu_program_loader #(.ADDR_WIDTH(4), .CYC_WIDTH(16)) dut_b (
    .clock(clock), .reset(rst_n), .start(b_start), .run_cycles(b_run_cycles),
    .byte_valid(b_valid), .byte_data(b_data), .byte_last(b_last),
    .byte_ready(b_byte_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_wdata(b_imem_wdata), .cpu_reset(b_cpu_reset), .cpu_clk_en(b_cpu_clk_en),
    .busy(b_busy), .done(b_done), .error(b_error), .words_loaded(b_words_loaded)
  );

  always #5 clock = ~clock;

  // Write/enable monitor, sampled on the falling edge.
  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  int cyc = 0;
  int en_count = 0;
  int last_we_cyc = -1;
  int first_en_cyc = -1;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      last_we_cyc <= cyc;
    end
    if (cpu_clk_en) begin
      en_count <= en_count + 1;
      if (first_en_cyc < 0) first_en_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    en_count = 0;
    last_we_cyc = -1;
    first_en_cyc = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int bound = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    while (!byte_ready && bound < 20) begin
      @(negedge clock);
      bound++;
    end
    chk("send_ready", {31'b0, byte_ready}, 32'd1);
    @(negedge clock);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_done();
    int bound = 0;
    while (!done && bound < 400) begin
      @(negedge clock);
      bound++;
    end
    chk("done_wait", {31'b0, done}, 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [31:0] d0, input logic [31:0] d1);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
    if (wa.size() >= 1) begin
      chk({tag, "_addr0"}, {22'b0, wa[0]}, 32'h0);
      chk({tag, "_data0"}, wd[0], d0);
    end
    if (wa.size() >= 2 && n >= 2) begin
      chk({tag, "_addr1"}, {22'b0, wa[1]}, 32'h4);
      chk({tag, "_data1"}, wd[1], d1);
    end
  endtask

  logic [7:0] img [8];
  logic [3:0] b_wa [8];
  logic [31:0] b_last_wd;

  initial begin
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h10; img[3] = 8'h00;
    img[4] = 8'h93; img[5] = 8'h05; img[6] = 8'h20; img[7] = 8'h00;

    // Reset state
    @(negedge clock);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_clk_en", {31'b0, cpu_clk_en}, 32'd0);
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_imem_addr", {22'b0, imem_addr}, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_flags", {29'b0, busy, done, error}, 32'd0);
    chk("rst_words", {23'b0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    // Byte stream ignored while idle
    byte_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("idle_no_ready", {31'b0, byte_ready}, 32'd0);
    byte_valid = 1'b0;

    // Two-word image, three run cycles
    clear_mon();
    run_cycles = 16'd3;
    pulse_start();
    chk("t1_ready_lat", {31'b0, byte_ready}, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(img[i], i == 7);
    wait_done();
    check_writes("t1", 2, 32'h00100513, 32'h00200593);
    chk("t1_words", {23'b0, words_loaded}, 32'd2);
    chk("t1_en_count", 32'(en_count), 32'd3);
    chk("t1_en_latency", 32'(first_en_cyc - last_we_cyc), 32'd2);
    chk("t1_done_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("t1_done_clk_en", {31'b0, cpu_clk_en}, 32'd0);

    // Short tail is zero-padded; zero budget goes straight to DONE
    clear_mon();
    run_cycles = 16'd0;
    pulse_start();
    chk("t2_reset_reassert", {31'b0, cpu_reset}, 32'd1);
    chk("t2_words_cleared", {23'b0, words_loaded}, 32'd0);
    chk("t2_done_cleared", {31'b0, done}, 32'd0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'hAB, 1'b1);
    wait_done();
    check_writes("t2", 2, 32'h44332211, 32'h000000AB);
    chk("t2_words", {23'b0, words_loaded}, 32'd2);
    chk("t2_en_never", 32'(en_count), 32'd0);

    // Stalling source with stray start pulses
    clear_mon();
    run_cycles = 16'd3;
    pulse_start();
    begin
      int i = 0;
      int bound = 0;
      while (i < 8 && bound < 400) begin
        byte_valid = 1'($urandom_range(0, 1));
        byte_data  = img[i];
        byte_last  = (i == 7);
        start      = ($urandom_range(0, 3) == 0);
        if (byte_ready && byte_valid) i++;
        @(negedge clock);
        bound++;
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      start      = 1'b0;
      chk("t3_all_bytes", 32'(i), 32'd8);
    end
    wait_done();
    check_writes("t3", 2, 32'h00100513, 32'h00200593);
    chk("t3_words", {23'b0, words_loaded}, 32'd2);
    chk("t3_en_count", 32'(en_count), 32'd3);

    // Asynchronous reset in the middle of a long run
    clear_mon();
    run_cycles = 16'd200;
    pulse_start();
    send_byte(8'h13, 1'b1);
    begin
      int bound = 0;
      while (!cpu_clk_en && bound < 20) begin
        @(negedge clock);
        bound++;
      end
      chk("t4_run_entered", {31'b0, cpu_clk_en}, 32'd1);
    end
    repeat (100) @(negedge clock);
    chk("t4_still_running", {31'b0, cpu_clk_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_clk_en", {31'b0, cpu_clk_en}, 32'd0);
    chk("t4_async_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("t4_async_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    clear_mon();
    run_cycles = 16'd1;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    wait_done();
    check_writes("t4_reload", 1, 32'h04030201, 32'h0);
    chk("t4_words", {23'b0, words_loaded}, 32'd1);
    chk("t4_en_count", 32'(en_count), 32'd1);

    // Overflow on a 16-byte memory
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    b_valid = 1'b1;
    begin
      int acc = 0;
      int bw = 0;
      for (int k = 0; k < 120; k++) begin
        b_data = 8'(acc);
        if (b_byte_ready) acc++;
        if (b_imem_we) begin
          if (bw < 8) b_wa[bw] = b_imem_addr;
          b_last_wd = b_imem_wdata;
          bw++;
        end
        @(negedge clock);
      end
      b_valid = 1'b0;
      chk("ovf_bytes_accepted", 32'(acc), 32'd16);
      chk("ovf_writes", 32'(bw), 32'd4);
      for (int k = 0; k < 4; k++) chk("ovf_addr", {28'b0, b_wa[k]}, 32'(4 * k));
      chk("ovf_last_data", b_last_wd, 32'h0F0E0D0C);
    end
    chk("ovf_error", {31'b0, b_error}, 32'd1);
    chk("ovf_cpu_reset", {31'b0, b_cpu_reset}, 32'd1);
    chk("ovf_no_ready", {31'b0, b_byte_ready}, 32'd0);
    chk("ovf_words", {29'b0, b_words_loaded}, 32'd4);
    chk("ovf_not_busy", {31'b0, b_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
